// File: rtl/roi_overlay_tx_if.sv
// roi_overlay_tx_if: video bus between the rx pixel source, the overlay
// block and the tx side. The master modport belongs to whoever sources rx
// video and sinks tx video; the slave modport belongs to the overlay block.
interface roi_overlay_tx_if;
  logic        rx_de;
  logic        rx_hsync;
  logic        rx_vsync;
  logic [7:0]  pixel_in;
  logic        tx_de;
  logic        tx_hsync;
  logic        tx_vsync;
  logic [23:0] pixel_out;

  modport master (
    output rx_de, rx_hsync, rx_vsync, pixel_in,
    input  tx_de, tx_hsync, tx_vsync, pixel_out
  );

  modport slave (
    input  rx_de, rx_hsync, rx_vsync, pixel_in,
    output tx_de, tx_hsync, tx_vsync, pixel_out
  );
endinterface

// File: rtl/roi_overlay_tx.sv
// roi_overlay_tx: re-emits the rx video stream on the tx side with the
// tracked ROI drawn as a coloured box. The ROI centre is latched once per
// frame on the vsync rising edge, so the box never tears mid-frame.
// Every output trails its rx input by exactly two pixel clocks.
// Optional build macro CROSSHAIR_EN adds a centre cross inside the box.
module roi_overlay_tx #(
  parameter int          BOX_HALF  = 10,
  parameter logic [23:0] BOX_COLOR = 24'hFF0000,
  parameter int          MAX_X     = 1919,
  parameter int          MAX_Y     = 1079
) (
  input  logic            rx_pclk,
  input  logic            rst,
  roi_overlay_tx_if.slave vid,
  input  logic [11:0]     point_x0,
  input  logic [10:0]     point_y0,
  input  logic            enable_overlay,
  output logic            overlay_active
);

  typedef enum logic {WAIT_FRAME, DRAW} frame_state_t;

  localparam logic [11:0] X_SAT   = 12'hFFF;
  localparam logic [10:0] Y_SAT   = 11'h7FF;
  localparam logic [12:0] HALF_X  = 13'(BOX_HALF);
  localparam logic [12:0] MAX_X13 = 13'(MAX_X);
  localparam logic [11:0] HALF_Y  = 12'(BOX_HALF);
  localparam logic [11:0] MAX_Y12 = 12'(MAX_Y);

  // stage 1 registers
  logic        de1_q, hs1_q, vs1_q;
  logic [7:0]  pix1_q;
  logic        border1_q;
  logic [11:0] x_cnt_q, x_cnt_d;
  logic [10:0] y_cnt_q, y_cnt_d;

  // stage 2 registers (drive the tx side directly)
  logic        de2_q, hs2_q, vs2_q;
  logic [23:0] pix2_q, pix2_d;

  // frame-latched box geometry
  frame_state_t state_q;
  logic         en_q;
  logic         overlay_q;
  logic [11:0]  l_q, r_q, l_d, r_d;
  logic [10:0]  t_q, b_q, t_d, b_d;

  // edge arithmetic intermediates
  logic [12:0] l_sum, r_sum;
  logic [11:0] t_sum, b_sum;

  logic vs_rise, de_fall, drawing, in_x, in_y, on_edge, border_d;

`ifdef CROSSHAIR_EN
  logic [11:0] cx_q;
  logic [10:0] cy_q;
  logic        on_cross;
`endif

  assign vs_rise = vid.rx_vsync & ~vs1_q;
  assign de_fall = ~vid.rx_de & de1_q;
  assign drawing = (state_q == DRAW) & en_q;

  // Next-state for the pixel/line counters; both saturate rather than wrap,
  // and a frame start wins over a line end on the row counter.
  always_comb begin
    x_cnt_d = x_cnt_q;
    y_cnt_d = y_cnt_q;
    if (de_fall) begin
      x_cnt_d = '0;
    end else if (vid.rx_de && x_cnt_q != X_SAT) begin
      x_cnt_d = x_cnt_q + 12'd1;
    end
    if (vs_rise) begin
      y_cnt_d = '0;
    end else if (de_fall && y_cnt_q != Y_SAT) begin
      y_cnt_d = y_cnt_q + 11'd1;
    end
  end

  // Box edges from the live centre point; the low side uses the sign bit of
  // a one-bit-wider difference, the high side clamps to the legal maximum.
  always_comb begin
    l_sum = {1'b0, point_x0} - HALF_X;
    r_sum = {1'b0, point_x0} + HALF_X;
    t_sum = {1'b0, point_y0} - HALF_Y;
    b_sum = {1'b0, point_y0} + HALF_Y;
    l_d   = l_sum[12] ? 12'd0 : l_sum[11:0];
    r_d   = (r_sum > MAX_X13) ? MAX_X13[11:0] : r_sum[11:0];
    t_d   = t_sum[11] ? 11'd0 : t_sum[10:0];
    b_d   = (b_sum > MAX_Y12) ? MAX_Y12[10:0] : b_sum[10:0];
  end

  // Border decision for the pixel currently on the rx inputs.
  always_comb begin
    in_x     = (x_cnt_q >= l_q) && (x_cnt_q <= r_q);
    in_y     = (y_cnt_q >= t_q) && (y_cnt_q <= b_q);
    on_edge  = (x_cnt_q == l_q) || (x_cnt_q == r_q) ||
               (y_cnt_q == t_q) || (y_cnt_q == b_q);
    border_d = drawing && vid.rx_de && in_x && in_y && on_edge;
`ifdef CROSSHAIR_EN
    on_cross = ((x_cnt_q == cx_q) && in_y) || ((y_cnt_q == cy_q) && in_x);
    border_d = border_d || (drawing && vid.rx_de && on_cross);
`endif
  end

  // Output pixel: box colour on the border, grey replicated otherwise,
  // black whenever the delayed data enable is low.
  always_comb begin
    pix2_d = '0;
    if (de1_q) begin
      pix2_d = border1_q ? BOX_COLOR : {3{pix1_q}};
    end
  end

  // Stage 1: register the rx stream, advance counters, capture border hit.
  always_ff @(posedge rx_pclk) begin
    if (rst) begin
      de1_q     <= 1'b0;
      hs1_q     <= 1'b0;
      vs1_q     <= 1'b0;
      pix1_q    <= '0;
      border1_q <= 1'b0;
      x_cnt_q   <= '0;
      y_cnt_q   <= '0;
    end else begin
      de1_q     <= vid.rx_de;
      hs1_q     <= vid.rx_hsync;
      vs1_q     <= vid.rx_vsync;
      pix1_q    <= vid.pixel_in;
      border1_q <= border_d;
      x_cnt_q   <= x_cnt_d;
      y_cnt_q   <= y_cnt_d;
    end
  end

  // Stage 2: registered tx outputs; sync and de are delayed, never altered.
  always_ff @(posedge rx_pclk) begin
    if (rst) begin
      de2_q  <= 1'b0;
      hs2_q  <= 1'b0;
      vs2_q  <= 1'b0;
      pix2_q <= '0;
    end else begin
      de2_q  <= de1_q;
      hs2_q  <= hs1_q;
      vs2_q  <= vs1_q;
      pix2_q <= pix2_d;
    end
  end

  // Frame FSM: waits for the first vsync rise after reset, then re-latches
  // the centre point, enable and box edges on every vsync rise.
  always_ff @(posedge rx_pclk) begin
    if (rst) begin
      state_q   <= WAIT_FRAME;
      en_q      <= 1'b0;
      overlay_q <= 1'b0;
      l_q       <= '0;
      r_q       <= '0;
      t_q       <= '0;
      b_q       <= '0;
    end else if (vs_rise) begin
      state_q   <= DRAW;
      en_q      <= enable_overlay;
      overlay_q <= enable_overlay;
      l_q       <= l_d;
      r_q       <= r_d;
      t_q       <= t_d;
      b_q       <= b_d;
    end
  end

`ifdef CROSSHAIR_EN
  // Cross centre is latched alongside the box edges.
  always_ff @(posedge rx_pclk) begin
    if (rst) begin
      cx_q <= '0;
      cy_q <= '0;
    end else if (vs_rise) begin
      cx_q <= point_x0;
      cy_q <= point_y0;
    end
  end
`endif

  assign vid.tx_de     = de2_q;
  assign vid.tx_hsync  = hs2_q;
  assign vid.tx_vsync  = vs2_q;
  assign vid.pixel_out = pix2_q;
  assign overlay_active = overlay_q;

endmodule

// File: tb/tb_roi_overlay_tx.sv
// tb_roi_overlay_tx: drives small 83x40 frames with random grey pixels and
// compares every tx cycle against a frame-level model of the box overlay.
// Build with CROSSHAIR_EN defined to also expect the centre cross.
module tb_roi_overlay_tx;
  localparam int          BOX_HALF  = 10;
  localparam logic [23:0] BOX_COLOR = 24'hFF0000;
  localparam int          MAX_X     = 1919;
  localparam int          MAX_Y     = 1079;
  localparam int          ACT_W     = 83;
  localparam int          ACT_H     = 40;
  localparam int          BLANK     = 10;

  typedef struct {
    logic        de;
    logic        hs;
    logic        vs;
    logic [23:0] pix;
  } expT;

  logic        rxPclk = 1'b0;
  logic        rst;
  logic [11:0] pointX0;
  logic [10:0] pointY0;
  logic        enableOverlay;
  logic        overlayActive;

  expT expQ[$];
  int  errors = 0;
  int  checks = 0;

  // frame-level model state
  bit mdlDraw, mdlEn, prevVs, ovExp;
  int mdlX0, mdlY0;

  roi_overlay_tx_if vif();

  roi_overlay_tx #(
    .BOX_HALF (BOX_HALF),
    .BOX_COLOR(BOX_COLOR),
    .MAX_X    (MAX_X),
    .MAX_Y    (MAX_Y)
  ) dut (
    .rx_pclk       (rxPclk),
    .rst           (rst),
    .vid           (vif.slave),
    .point_x0      (pointX0),
    .point_y0      (pointY0),
    .enable_overlay(enableOverlay),
    .overlay_active(overlayActive)
  );

  always #5 rxPclk = ~rxPclk;

  // is (x,y) coloured for the box centred on the latched point
  function automatic bit boxPixel(input int x, input int y);
    int l, r, t, b;
    bit inBox, onBorder;
    l = mdlX0 - BOX_HALF; if (l < 0) l = 0;
    r = mdlX0 + BOX_HALF; if (r > MAX_X) r = MAX_X;
    t = mdlY0 - BOX_HALF; if (t < 0) t = 0;
    b = mdlY0 + BOX_HALF; if (b > MAX_Y) b = MAX_Y;
    inBox    = (x >= l) && (x <= r) && (y >= t) && (y <= b);
    onBorder = inBox && ((x == l) || (x == r) || (y == t) || (y == b));
`ifdef CROSSHAIR_EN
    onBorder = onBorder || ((x == mdlX0) && (y >= t) && (y <= b))
                        || ((y == mdlY0) && (x >= l) && (x <= r));
`endif
    return onBorder;
  endfunction

  task automatic checkOutput();
    expT e;
    @(negedge rxPclk);
    checks++;
    assert (overlayActive === ovExp) else begin
      errors++;
      $error("[TB] FAIL overlay_active t=%0t got=%0b exp=%0b", $time, overlayActive, ovExp);
    end
    if (expQ.size() == 3) begin
      e = expQ.pop_front();
      checks++;
      assert (vif.tx_de === e.de) else begin
        errors++;
        $error("[TB] FAIL tx_de t=%0t got=%0b exp=%0b", $time, vif.tx_de, e.de);
      end
      checks++;
      assert (vif.tx_hsync === e.hs) else begin
        errors++;
        $error("[TB] FAIL tx_hsync t=%0t got=%0b exp=%0b", $time, vif.tx_hsync, e.hs);
      end
      checks++;
      assert (vif.tx_vsync === e.vs) else begin
        errors++;
        $error("[TB] FAIL tx_vsync t=%0t got=%0b exp=%0b", $time, vif.tx_vsync, e.vs);
      end
      checks++;
      assert (vif.pixel_out === e.pix) else begin
        errors++;
        $error("[TB] FAIL pixel_out t=%0t got=%h exp=%h", $time, vif.pixel_out, e.pix);
      end
    end
  endtask

  task automatic applyStimulus(input bit r, input bit de, input bit hs, input bit vs,
                               input logic [7:0] pix, input int x, input int y);
    expT e;
    expT zeroE;
    zeroE = '{1'b0, 1'b0, 1'b0, 24'h0};
    @(posedge rxPclk);
    #1;
    rst          = r;
    vif.rx_de    = de;
    vif.rx_hsync = hs;
    vif.rx_vsync = vs;
    vif.pixel_in = pix;
    ovExp = mdlDraw && mdlEn;
    if (r) begin
      if (expQ.size() > 0) expQ[$] = zeroE;
      e = zeroE;
    end else begin
      e.de  = de;
      e.hs  = hs;
      e.vs  = vs;
      e.pix = !de ? 24'h0 :
              ((mdlDraw && mdlEn && boxPixel(x, y)) ? BOX_COLOR : {pix, pix, pix});
    end
    expQ.push_back(e);
    if (r) begin
      mdlDraw = 0;
      mdlEn   = 0;
      prevVs  = 0;
    end else begin
      if (vs && !prevVs) begin
        mdlDraw = 1;
        mdlEn   = enableOverlay;
        mdlX0   = int'(pointX0);
        mdlY0   = int'(pointY0);
      end
      prevVs = vs;
    end
    checkOutput();
  endtask

  task automatic sendLine(input bit vs, input bit active, input int y);
    bit de, hs;
    for (int i = 0; i < ACT_W + BLANK; i++) begin
      de = active && (i < ACT_W);
      hs = (i >= ACT_W + 2) && (i < ACT_W + 6);
      applyStimulus(1'b0, de, hs, vs, 8'($urandom), de ? i : 0, y);
    end
  endtask

  task automatic sendFrame(input int x0, input int y0, input bit en,
                           input int x1, input int y1, input bit en1);
    pointX0       = 12'(x0);
    pointY0       = 11'(y0);
    enableOverlay = en;
    sendLine(1'b1, 1'b0, 0);
    sendLine(1'b1, 1'b0, 0);
    sendLine(1'b0, 1'b0, 0);
    for (int y = 0; y < ACT_H; y++) begin
      if (y == ACT_H / 2) begin
        pointX0       = 12'(x1);
        pointY0       = 11'(y1);
        enableOverlay = en1;
      end
      sendLine(1'b0, 1'b1, y);
    end
  endtask

  task automatic resetWithVideo(input int n);
    for (int i = 0; i < n; i++) begin
      applyStimulus(1'b1, i[0], 1'b0, 1'b0, 8'($urandom), 0, 0);
    end
  endtask

  initial begin
    rst           = 1'b1;
    vif.rx_de     = 1'b0;
    vif.rx_hsync  = 1'b0;
    vif.rx_vsync  = 1'b0;
    vif.pixel_in  = 8'h00;
    pointX0       = 12'd40;
    pointY0       = 11'd20;
    enableOverlay = 1'b1;
    mdlDraw = 0; mdlEn = 0; prevVs = 0; ovExp = 0;
    mdlX0 = 0; mdlY0 = 0;
    repeat (2) @(posedge rxPclk);

    $display("[TB] reset with active video");
    resetWithVideo(4);

    $display("[TB] partial first frame after reset, no box expected");
    for (int y = 0; y < 5; y++) sendLine(1'b0, 1'b1, y);

    $display("[TB] box at (40,20)");
    sendFrame(40, 20, 1'b1, 40, 20, 1'b1);

    $display("[TB] mid-frame point change ignored");
    sendFrame(40, 20, 1'b1, 60, 30, 1'b0);
    sendFrame(60, 30, 1'b1, 3, 2, 1'b1);

    $display("[TB] clipped box at (3,2) and box at (80,39)");
    sendFrame(3, 2, 1'b1, 80, 39, 1'b1);
    sendFrame(80, 39, 1'b1, 40, 20, 1'b1);

    $display("[TB] overlay disabled, passthrough");
    sendFrame(40, 20, 1'b0, 40, 20, 1'b1);

    $display("[TB] mid-frame reset");
    pointX0 = 12'd40; pointY0 = 11'd20; enableOverlay = 1'b1;
    sendLine(1'b1, 1'b0, 0);
    sendLine(1'b0, 1'b0, 0);
    for (int y = 0; y < 10; y++) sendLine(1'b0, 1'b1, y);
    resetWithVideo(3);
    for (int y = 0; y < 5; y++) sendLine(1'b0, 1'b1, y);
    sendFrame(40, 20, 1'b1, 50, 25, 1'b1);

    $display("[TB] random frames");
    for (int f = 0; f < 3; f++) begin
      sendFrame(int'($urandom_range(0, 90)), int'($urandom_range(0, 45)),
                1'($urandom_range(0, 1)),
                int'($urandom_range(0, 90)), int'($urandom_range(0, 45)),
                1'($urandom_range(0, 1)));
    end

    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
